// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel, W-bit registered multiplexer.
//   mode=0 : manual select, the output follows sel_in one cycle later.
//   mode=1 : auto-scan, an internal pointer visits each enabled channel
//            and holds it for DWELL cycles.
// Optional feature macro: CHMUX_FREEZE_EN adds a 'freeze' input that holds
// all state (scan_wrap forced low) while asserted.
module chan_scan_mux #(
  parameter  int N_CH  = 4,
  parameter  int W     = 4,
  parameter  int DWELL = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH*W-1:0] in_bus,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  output logic              scan_wrap
`ifdef CHMUX_FREEZE_EN
  ,
  input  logic              freeze
`endif
);

  localparam int               CNT_W    = $clog2(DWELL + 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic hold;
`ifdef CHMUX_FREEZE_EN
  assign hold = freeze;
`else
  assign hold = 1'b0;
`endif

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic             scan_wrap_q, scan_wrap_d;

  // Channel lookups; an index beyond N_CH-1 matches nothing and reads as
  // "not a legal channel".
  logic             sel_ok, sel_en, ptr_ok, ptr_en;
  logic [W-1:0]     sel_data, ptr_data;
  logic [SEL_W-1:0] next_ptr, cand;
  logic             found;

  function automatic logic en_at(input logic [N_CH-1:0] en, input logic [SEL_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (idx == SEL_W'(k)) r = en[k];
    end
    return r;
  endfunction

  // Decode the manual select and the scan pointer into data/enable.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sel_ok   = 1'b0;
    sel_en   = 1'b0;
    sel_data = '0;
    ptr_ok   = 1'b0;
    ptr_en   = 1'b0;
    ptr_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_in == SEL_W'(k)) begin
        sel_ok   = 1'b1;
        sel_en   = ch_en[k];
        sel_data = in_bus[k*W +: W];
      end
      if (ptr_q == SEL_W'(k)) begin
        ptr_ok   = 1'b1;
        ptr_en   = ch_en[k];
        ptr_data = in_bus[k*W +: W];
      end
    end
  end

  // Next enabled channel strictly above the pointer, wrapping explicitly at
  // N_CH-1 so non-power-of-2 channel counts never visit a phantom index.
  // A lone enabled channel finds itself after a full lap.
  always_comb begin
    next_ptr = ptr_q;
    found    = 1'b0;
    cand     = ptr_q;
    for (int i = 0; i < N_CH; i++) begin
      cand = (cand >= LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && en_at(ch_en, cand)) begin
        next_ptr = cand;
        found    = 1'b1;
      end
    end
  end

  // Next-state logic for pointer, dwell counter and registered outputs.
  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    scan_wrap_d = 1'b0;
    if (!hold) begin
      if (!mode) begin
        // Manual: the counter idles at zero so auto mode starts a fresh dwell.
        ptr_d       = sel_in;
        cnt_d       = '0;
        out_sel_d   = sel_in;
        out_valid_d = sel_ok & sel_en;
        if (sel_ok) out_data_d = sel_data;
      end else begin
        out_sel_d   = ptr_q;
        out_valid_d = ptr_ok & ptr_en;
        if (ptr_ok) out_data_d = ptr_data;
        // With nothing enabled the scan parks: pointer and counter hold.
        if (|ch_en) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            ptr_d       = next_ptr;
            scan_wrap_d = (next_ptr <= ptr_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // State registers; reset clears everything regardless of freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench for chan_scan_mux: a 4-channel instance driven from a
// vector table and a cycle model (scoreboard), plus hand-written sequences on
// a 3-channel instance and a DWELL=1 instance.
module tb_chan_scan_mux;

  localparam int N_CH  = 4;
  localparam int W     = 4;
  localparam int DWELL = 4;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] sel;
    logic       valid;
    logic       wrap;
  } exp_t;

  typedef struct packed {
    logic        md;
    logic [1:0]  sel;
    logic [3:0]  en;
    logic [15:0] bus;
    exp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main 4-channel instance
  logic        mode, freeze;
  logic [1:0]  sel_in;
  logic [3:0]  ch_en;
  logic [15:0] in_bus;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid, scan_wrap;

  // 3-channel instance
  logic        mode3;
  logic [1:0]  sel3;
  logic [2:0]  en3;
  logic [11:0] bus3;
  logic [3:0]  data3;
  logic [1:0]  osel3;
  logic        valid3, wrap3;

  // DWELL=1 instance
  logic        mode1;
  logic [1:0]  sel1;
  logic [3:0]  en1;
  logic [15:0] bus1;
  logic [3:0]  data1;
  logic [1:0]  osel1;
  logic        valid1, wrap1;

  chan_scan_mux #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_in(sel_in), .ch_en(ch_en),
    .in_bus(in_bus), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .scan_wrap(scan_wrap)
`ifdef CHMUX_FREEZE_EN
    , .freeze(freeze)
`endif
  );

  chan_scan_mux #(.N_CH(3), .W(4), .DWELL(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel_in(sel3), .ch_en(en3),
    .in_bus(bus3), .out_data(data3), .out_sel(osel3),
    .out_valid(valid3), .scan_wrap(wrap3)
`ifdef CHMUX_FREEZE_EN
    , .freeze(freeze)
`endif
  );

  chan_scan_mux #(.N_CH(4), .W(4), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode1), .sel_in(sel1), .ch_en(en1),
    .in_bus(bus1), .out_data(data1), .out_sel(osel1),
    .out_valid(valid1), .scan_wrap(wrap1)
`ifdef CHMUX_FREEZE_EN
    , .freeze(freeze)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the 4-channel instance
  logic [1:0] m_ptr;
  int         m_cnt;
  exp_t       m_out;
  exp_t       sb_q[$];

  task automatic model_reset();
    m_ptr = '0;
    m_cnt = 0;
    m_out = '0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic md, input logic [1:0] s, input logic [3:0] en,
                            input logic [15:0] bus, input logic fz);
    int nxt;
    m_out.wrap = 1'b0;
    if (fz) return;
    if (!md) begin
      m_ptr       = s;
      m_cnt       = 0;
      m_out.sel   = s;
      m_out.data  = bus[int'(s)*W +: W];
      m_out.valid = en[s];
    end else begin
      m_out.sel   = m_ptr;
      m_out.data  = bus[int'(m_ptr)*W +: W];
      m_out.valid = en[m_ptr];
      if (en != 4'h0) begin
        if (m_cnt == DWELL - 1) begin
          m_cnt = 0;
          nxt   = int'(m_ptr);
          for (int i = 1; i <= N_CH; i++) begin
            if (en[(int'(m_ptr) + i) % N_CH]) begin
              nxt = (int'(m_ptr) + i) % N_CH;
              break;
            end
          end
          m_out.wrap = (nxt <= int'(m_ptr));
          m_ptr      = 2'(nxt);
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  // Drive one cycle, push the expected result, pop and compare after the edge.
  task automatic cycle(input logic md, input logic [1:0] s, input logic [3:0] en,
                       input logic [15:0] bus, input logic fz,
                       input bit use_tbl, input exp_t texp, input string name);
    exp_t e;
    mode = md; sel_in = s; ch_en = en; in_bus = bus; freeze = fz;
    model_step(md, s, en, bus, fz);
    sb_q.push_back(use_tbl ? texp : m_out);
    tick();
    e = sb_q.pop_front();
    check({name, "_data"},  32'(out_data),  32'(e.data));
    check({name, "_sel"},   32'(out_sel),   32'(e.sel));
    check({name, "_valid"}, 32'(out_valid), 32'(e.valid));
    check({name, "_wrap"},  32'(scan_wrap), 32'(e.wrap));
  endtask

  function automatic vec_t mk(input logic md, input logic [1:0] s, input logic [3:0] en,
                              input logic [15:0] bus, input logic [3:0] d,
                              input logic [1:0] os, input logic v);
    vec_t r;
    r.md = md; r.sel = s; r.en = en; r.bus = bus;
    r.exp.data = d; r.exp.sel = os; r.exp.valid = v; r.exp.wrap = 1'b0;
    return r;
  endfunction

  initial begin
    vec_t  tv[8];
    exp_t  nil;
    int    wraps;
    logic [1:0] held_sel;
    logic  md_r, fz_r;
    logic [3:0] en_r;

    nil = '0;
    tv[0] = mk(1'b0, 2'd2, 4'hF, 16'hDCBA, 4'hC, 2'd2, 1'b1);
    tv[1] = mk(1'b0, 2'd0, 4'hF, 16'hDCBA, 4'hA, 2'd0, 1'b1);
    tv[2] = mk(1'b0, 2'd3, 4'hF, 16'hDCBA, 4'hD, 2'd3, 1'b1);
    tv[3] = mk(1'b0, 2'd2, 4'hB, 16'hDCBA, 4'hC, 2'd2, 1'b0);
    tv[4] = mk(1'b0, 2'd1, 4'hB, 16'h1234, 4'h3, 2'd1, 1'b1);
    tv[5] = mk(1'b0, 2'd1, 4'hB, 16'h5678, 4'h7, 2'd1, 1'b1);
    tv[6] = mk(1'b0, 2'd3, 4'h7, 16'h5678, 4'h5, 2'd3, 1'b0);
    tv[7] = mk(1'b0, 2'd0, 4'hE, 16'h5678, 4'h8, 2'd0, 1'b0);

    mode = 0; sel_in = 0; ch_en = 0; in_bus = 0; freeze = 0;
    mode3 = 0; sel3 = 0; en3 = 0; bus3 = 0;
    mode1 = 0; sel1 = 0; en1 = 4'hF; bus1 = 16'hDCBA;
    model_reset();

    // Reset state
    #12;
    check("rst_data",  32'(out_data),  0);
    check("rst_sel",   32'(out_sel),   0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_wrap",  32'(scan_wrap), 0);
    rst_n = 1'b1;

    // Manual mode vector table
    foreach (tv[i])
      cycle(tv[i].md, tv[i].sel, tv[i].en, tv[i].bus, 1'b0, 1'b1, tv[i].exp, $sformatf("tbl%0d", i));

    // Auto scan over all four channels
    cycle(1'b0, 2'd0, 4'hF, 16'hDCBA, 1'b0, 1'b0, nil, "pre_auto");
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 2'd0, 4'hF, 16'hDCBA, 1'b0, 1'b0, nil, "auto_f");
      check("auto_f_seq", 32'(out_sel), 32'((i / 4) % 4));
      if (i < 16 && scan_wrap) wraps++;
    end
    check("auto_f_wraps16", 32'(wraps), 1);

    // Auto scan over channels 0 and 2, then all channels disabled
    cycle(1'b0, 2'd0, 4'h5, 16'h4321, 1'b0, 1'b0, nil, "pre_alt");
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 2'd3, 4'h5, 16'h4321, 1'b0, 1'b0, nil, "auto_5");
      check("auto_5_seq", 32'(out_sel), ((i / 4) % 2 == 1) ? 2 : 0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 2'd0, 4'h0, 16'h4321, 1'b0, 1'b0, nil, "auto_off");
      check("auto_off_sel", 32'(out_sel), 2);
      check("auto_off_valid", 32'(out_valid), 0);
    end

`ifdef CHMUX_FREEZE_EN
    // Freeze in auto mode, then resume the remaining dwell
    cycle(1'b0, 2'd1, 4'hF, 16'hDCBA, 1'b0, 1'b0, nil, "pre_frz");
    cycle(1'b1, 2'd0, 4'hF, 16'hDCBA, 1'b0, 1'b0, nil, "frz_run");
    cycle(1'b1, 2'd0, 4'hF, 16'hDCBA, 1'b0, 1'b0, nil, "frz_run");
    held_sel = out_sel;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'd0, 4'hF, 16'hDCBA, 1'b1, 1'b0, nil, "frz_hold");
      check("frz_sel_const", 32'(out_sel), 32'(held_sel));
      check("frz_wrap_low", 32'(scan_wrap), 0);
    end
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 2'd0, 4'hF, 16'hDCBA, 1'b0, 1'b0, nil, "frz_resume");
`endif

    // Randomised mode/select/enable/data traffic against the model
    for (int i = 0; i < 300; i++) begin
      md_r = ($urandom_range(0, 9) < 7);
      en_r = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
`ifdef CHMUX_FREEZE_EN
      fz_r = ($urandom_range(0, 7) == 0);
`else
      fz_r = 1'b0;
`endif
      cycle(md_r, 2'($urandom_range(0, 3)), en_r, 16'($urandom), fz_r, 1'b0, nil, "rnd");
    end

    // Reset asserted mid-scan, checked before any clock edge
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 2'd0, 4'hF, 16'hDCBA, 1'b0, 1'b0, nil, "pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data",  32'(out_data),  0);
    check("mid_rst_sel",   32'(out_sel),   0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_wrap",  32'(scan_wrap), 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 2'd0, 4'hF, 16'hDCBA, 1'b0, 1'b0, nil, "post_rst");
    mode = 1'b0;

    // Three channels: out-of-range select and 2->0 wrap
    en3 = 3'h7; bus3 = 12'h987; sel3 = 2'd1; mode3 = 1'b0;
    tick();
    check("n3_data",  32'(data3),  4'h8);
    check("n3_sel",   32'(osel3),  1);
    check("n3_valid", 32'(valid3), 1);
    sel3 = 2'd3;
    tick();
    check("n3_oor_valid", 32'(valid3), 0);
    check("n3_oor_data",  32'(data3),  4'h8);
    sel3 = 2'd2;
    tick();
    check("n3_sel2_data", 32'(data3), 4'h9);
    mode3 = 1'b1;
    tick(); tick(); tick();
    check("n3_auto_sel",  32'(osel3), 2);
    check("n3_auto_nowrap", 32'(wrap3), 0);
    tick();
    check("n3_wrap", 32'(wrap3), 1);
    tick();
    check("n3_after_sel",  32'(osel3), 0);
    check("n3_after_wrap", 32'(wrap3), 0);
    check("n3_after_data", 32'(data3), 4'h7);
    mode3 = 1'b0;

    // DWELL=1: a new channel every cycle
    mode1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("d1_sel",  32'(osel1), 32'(i % 4));
      check("d1_wrap", 32'(wrap1), (i == 3) ? 1 : 0);
    end
    check("d1_data", 32'(data1), 4'hA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
